// File: rtl/controlador_display_mux_pkg.sv
// Shared definitions for the multiplexed 7-segment display driver:
// active-low segment patterns {g,f,e,d,c,b,a} and the per-digit slot state encoding.
package controlador_display_mux_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic {
        GUARDA  = 1'b0,
        MUESTRA = 1'b1
    } slot_e;

endpackage

// File: rtl/controlador_display_mux_decodificador.sv
// Combinational BCD to active-low 7-segment decoder; non-BCD nibbles render blank.
module decodificador_bcd_7seg
    import controlador_display_mux_pkg::*;
(
    input  logic [3:0] iBcd,
    output logic [6:0] oSeg
);

    // nibble to segment pattern lookup
    always_comb begin
        oSeg = SEG_BLANK;
        case (iBcd)
            4'd0:    oSeg = SEG_0;
            4'd1:    oSeg = SEG_1;
            4'd2:    oSeg = SEG_2;
            4'd3:    oSeg = SEG_3;
            4'd4:    oSeg = SEG_4;
            4'd5:    oSeg = SEG_5;
            4'd6:    oSeg = SEG_6;
            4'd7:    oSeg = SEG_7;
            4'd8:    oSeg = SEG_8;
            4'd9:    oSeg = SEG_9;
            default: oSeg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/controlador_display_mux.sv
// Time-multiplexed N-digit common-anode 7-segment driver with a frame-synchronous
// load handshake, ghosting guard at the start of each digit slot and leading-zero blanking.
module controlador_display_mux
    import controlador_display_mux_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                  iClk,
    input  logic                  iReset,
    input  logic                  iLoad,
    input  logic [4*N_DIGITS-1:0] iDato,
    input  logic                  iBlankZeros,
    output logic                  oBusy,
    output logic [6:0]            oSeg,
    output logic [N_DIGITS-1:0]   oAnodo,
    output logic                  oFrame
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int DW = 4 * N_DIGITS;
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);
    localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYCLES);
    localparam slot_e         SLOT_RST   = (BLANK_CYCLES > 0) ? GUARDA : MUESTRA;

    logic [PW-1:0]       presc_q, presc_d;
    logic [IW-1:0]       idx_q, idx_d;
    slot_e               slot_q, slot_d;
    logic [DW-1:0]       pend_q, pend_d;
    logic [DW-1:0]       disp_q, disp_d;
    logic                busy_q, busy_d;
    logic [6:0]          seg_q, seg_d;
    logic [N_DIGITS-1:0] anodo_q, anodo_d;
    logic                frame_q, frame_d;
    logic                frame_end_s;
    logic [3:0]          nibble_s;
    logic [6:0]          dec_seg_s;
    logic                lz_blank_s;

    // prescaler and digit index; frame end is the last cycle of the last digit
    always_comb begin
        presc_d     = presc_q + PW'(1);
        idx_d       = idx_q;
        frame_end_s = 1'b0;
        if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            if (idx_q == IDX_LAST) begin
                idx_d       = '0;
                frame_end_s = 1'b1;
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end else begin
            presc_d = presc_q + PW'(1);
        end
    end

    // slot FSM next state, tracking where the next prescaler value falls
    always_comb begin
        slot_d = slot_q;
        case (slot_q)
            GUARDA: begin
                if (presc_d >= BLANK_END) slot_d = MUESTRA;
                else                      slot_d = GUARDA;
            end
            MUESTRA: begin
                if (presc_d < BLANK_END) slot_d = GUARDA;
                else                     slot_d = MUESTRA;
            end
            default: slot_d = SLOT_RST;
        endcase
    end

    // load handshake: a load landing on the frame-end cycle bypasses the pending stage
    always_comb begin
        pend_d = pend_q;
        disp_d = disp_q;
        busy_d = busy_q;
        if (frame_end_s) begin
            if (iLoad) begin
                pend_d = iDato;
                disp_d = iDato;
                busy_d = 1'b0;
            end else if (busy_q) begin
                disp_d = pend_q;
                busy_d = 1'b0;
            end else begin
                busy_d = 1'b0;
            end
        end else if (iLoad) begin
            pend_d = iDato;
            busy_d = 1'b1;
        end else begin
            busy_d = busy_q;
        end
    end

    assign nibble_s   = disp_q[{idx_q, 2'b00} +: 4];
    assign lz_blank_s = iBlankZeros && (idx_q != '0) && ((disp_q >> {idx_q, 2'b00}) == '0);

    decodificador_bcd_7seg u_dec (
        .iBcd (nibble_s),
        .oSeg (dec_seg_s)
    );

    // output pattern for the current counter state, registered one cycle later
    always_comb begin
        seg_d   = SEG_BLANK;
        anodo_d = '1;
        frame_d = (presc_q == '0) && (idx_q == '0);
        case (slot_q)
            MUESTRA: begin
                anodo_d[idx_q] = 1'b0;
                if (lz_blank_s) seg_d = SEG_BLANK;
                else            seg_d = dec_seg_s;
            end
            GUARDA: begin
                seg_d   = SEG_BLANK;
                anodo_d = '1;
            end
            default: begin
                seg_d   = SEG_BLANK;
                anodo_d = '1;
            end
        endcase
    end

    // state and output registers
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            presc_q <= '0;
            idx_q   <= '0;
            slot_q  <= SLOT_RST;
            pend_q  <= '0;
            disp_q  <= '0;
            busy_q  <= 1'b0;
            seg_q   <= SEG_BLANK;
            anodo_q <= '1;
            frame_q <= 1'b0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            slot_q  <= slot_d;
            pend_q  <= pend_d;
            disp_q  <= disp_d;
            busy_q  <= busy_d;
            seg_q   <= seg_d;
            anodo_q <= anodo_d;
            frame_q <= frame_d;
        end
    end

    assign oBusy  = busy_q;
    assign oSeg   = seg_q;
    assign oAnodo = anodo_q;
    assign oFrame = frame_q;

endmodule
